// File: rtl/rsp_s1_prep_feeder_if.sv
// Stream/multiplier bus of the prep feeder: the upstream sample handshake and
// the sample/twiddle pair presented to the prep multiplier.
interface rsp_s1_prep_feeder_if #(
  parameter int SAMPLE_WIDTH  = 32,
  parameter int TWIDDLE_WIDTH = 48,
  parameter int NUM           = 8
);
  localparam int IW = $clog2(NUM);

  logic [SAMPLE_WIDTH-1:0]  i_s_data;
  logic                     i_s_valid;
  logic                     o_s_ready;
  logic [SAMPLE_WIDTH-1:0]  o_x0_data;
  logic [TWIDDLE_WIDTH-1:0] o_w;
  logic                     o_x0_valid;
  logic                     o_switch;
  logic [IW-1:0]            o_idx;

  // slave = the feeder itself; master = upstream source plus multiplier sink
  modport slave (
    input  i_s_data, i_s_valid,
    output o_s_ready, o_x0_data, o_w, o_x0_valid, o_switch, o_idx
  );

  modport master (
    output i_s_data, i_s_valid,
    input  o_s_ready, o_x0_data, o_w, o_x0_valid, o_switch, o_idx
  );
endinterface

// File: rtl/rsp_s1_prep_feeder.sv
// Frame sequencer for the rsp_s1 prep multiplier: pairs NUM upstream samples
// with table twiddles, then waits out the multiplier latency before o_done.
module rsp_s1_prep_feeder #(
  parameter int TWIDDLE_WIDTH     = 48,
  parameter int SAMPLE_WIDTH      = 32,
  parameter int NUM               = 8,
  parameter int MUL_COMPLEX_VALID = 6,
  parameter int MUL_REAL_VALID    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_bypass,
  input  logic                     i_abort,
  input  logic                     i_cfg_we,
  input  logic [$clog2(NUM)-1:0]   i_cfg_addr,
  input  logic [TWIDDLE_WIDTH-1:0] i_cfg_wdata,
  rsp_s1_prep_feeder_if.slave      bus,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cfg_err
);
  localparam int CW   = $clog2(NUM);
  localparam int MAXL = (MUL_COMPLEX_VALID > MUL_REAL_VALID) ? MUL_COMPLEX_VALID : MUL_REAL_VALID;
  localparam int DW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                   r_state, w_state_next;
  logic                     r_mode, w_mode_next;
  logic [CW-1:0]            r_cnt, w_cnt_next;
  logic [DW-1:0]            r_drain, w_drain_next;
  logic [SAMPLE_WIDTH-1:0]  r_x0_data, w_x0_data_next;
  logic [TWIDDLE_WIDTH-1:0] r_w, w_w_next;
  logic [CW-1:0]            r_idx, w_idx_next;
  logic                     r_x0_valid, w_x0_valid_next;
  logic                     r_done, w_done_next;
  logic                     r_cfg_err, w_cfg_err_next;

  logic [TWIDDLE_WIDTH-1:0] r_table [NUM];
  logic [NUM-1:0]           w_entry_we;
  logic                     w_tbl_we;
  logic                     w_accept;

  // abort wins over the sample offered in the same cycle
  assign w_accept = bus.i_s_valid && (r_state == S_RUN) && !i_abort;
  assign w_tbl_we = i_cfg_we && (r_state == S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_entry_we
      assign w_entry_we[gi] = w_tbl_we && (i_cfg_addr == CW'(gi));
    end
  endgenerate

  // Coefficient table is deliberately not reset so a reset keeps loaded twiddles.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM; k++) begin
      if (w_entry_we[k]) r_table[k] <= i_cfg_wdata;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mode_next     = r_mode;
    w_cnt_next      = r_cnt;
    w_drain_next    = r_drain;
    w_x0_data_next  = r_x0_data;
    w_w_next        = r_w;
    w_idx_next      = r_idx;
    w_x0_valid_next = 1'b0;
    w_done_next     = 1'b0;
    w_cfg_err_next  = i_cfg_we && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_next = S_RUN;
          w_mode_next  = i_bypass;
          w_cnt_next   = '0;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (w_accept) begin
          w_x0_valid_next = 1'b1;
          w_x0_data_next  = bus.i_s_data;
          w_w_next        = r_table[r_cnt];
          w_idx_next      = r_cnt;
          if (r_cnt == CW'(NUM - 1)) begin
            w_cnt_next   = '0;
            w_state_next = S_DRAIN;
            w_drain_next = r_mode ? DW'(MUL_REAL_VALID) : DW'(MUL_COMPLEX_VALID);
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          w_state_next = S_IDLE;
          w_drain_next = '0;
        end else if (r_drain <= DW'(1)) begin
          // counter hits zero on this edge: done and IDLE appear together
          w_drain_next = '0;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_drain_next = r_drain - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_cnt      <= '0;
      r_drain    <= '0;
      r_x0_data  <= '0;
      r_w        <= '0;
      r_idx      <= '0;
      r_x0_valid <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_mode     <= w_mode_next;
      r_cnt      <= w_cnt_next;
      r_drain    <= w_drain_next;
      r_x0_data  <= w_x0_data_next;
      r_w        <= w_w_next;
      r_idx      <= w_idx_next;
      r_x0_valid <= w_x0_valid_next;
      r_done     <= w_done_next;
      r_cfg_err  <= w_cfg_err_next;
    end
  end

  assign bus.o_s_ready  = (r_state == S_RUN);
  assign bus.o_x0_data  = r_x0_data;
  assign bus.o_w        = r_w;
  assign bus.o_x0_valid = r_x0_valid;
  assign bus.o_switch   = r_mode;
  assign bus.o_idx      = r_idx;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_cfg_err      = r_cfg_err;
endmodule

// File: tb/tb_rsp_s1_prep_feeder.sv
// Directed frame sequence with random data/stalls, checked against a
// frame-level model (table copy, accept count, drain latency).
module tb_rsp_s1_prep_feeder;
  localparam int TW  = 48;
  localparam int SW  = 32;
  localparam int NUM = 8;
  localparam int LC  = 6;
  localparam int LR  = 3;
  localparam int AW  = $clog2(NUM);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_bypass, i_abort, i_cfg_we;
  logic [AW-1:0] i_cfg_addr;
  logic [TW-1:0] i_cfg_wdata;
  logic          o_busy, o_done, o_cfg_err;

  rsp_s1_prep_feeder_if #(.SAMPLE_WIDTH(SW), .TWIDDLE_WIDTH(TW), .NUM(NUM)) bus ();

  rsp_s1_prep_feeder #(
    .TWIDDLE_WIDTH(TW), .SAMPLE_WIDTH(SW), .NUM(NUM),
    .MUL_COMPLEX_VALID(LC), .MUL_REAL_VALID(LR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_bypass(i_bypass),
    .i_abort(i_abort), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_wdata(i_cfg_wdata), .bus(bus), .o_busy(o_busy),
    .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [TW-1:0] m_tbl [NUM];
  int            m_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_done"},  64'(o_done), 64'd0);
    chk({tag, "_err"},   64'(o_cfg_err), 64'd0);
    chk({tag, "_valid"}, 64'(bus.o_x0_valid), 64'd0);
    chk({tag, "_data"},  64'(bus.o_x0_data), 64'd0);
    chk({tag, "_w"},     64'(bus.o_w), 64'd0);
    chk({tag, "_idx"},   64'(bus.o_idx), 64'd0);
    chk({tag, "_sw"},    64'(bus.o_switch), 64'd0);
    chk({tag, "_rdy"},   64'(bus.o_s_ready), 64'd0);
  endtask

  task automatic cfg_write(input int addr, input logic [TW-1:0] data);
    i_cfg_we = 1'b1; i_cfg_addr = AW'(addr); i_cfg_wdata = data;
    @(negedge clk);
    i_cfg_we = 1'b0;
    m_tbl[addr] = data;
    chk("cfg_idle_err", 64'(o_cfg_err), 64'd0);
  endtask

  // vmode: 0 = valid always high, 1 = pattern 1,0,0, 2 = random
  task automatic run_frame(input string name, input bit byp, input int vmode,
                           input int abort_at, input bit cfg_run, input bit rst_drain,
                           input bit fixed_data, input bit wr_at_start);
    int            k = 0;
    int            cyc = 0;
    bit            acc;
    bit            aborted = 0;
    int            lat;
    logic [SW-1:0] samp;
    logic [TW-1:0] wdat;

    i_start = 1'b1; i_bypass = byp;
    if (wr_at_start) begin
      wdat = {16'h0, $urandom};
      i_cfg_we = 1'b1; i_cfg_addr = '0; i_cfg_wdata = wdat;
      m_tbl[0] = wdat;
    end
    @(negedge clk);
    i_start = 1'b0; i_cfg_we = 1'b0;
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_rdy",  64'(bus.o_s_ready), 64'd1);
    chk("start_sw",   64'(bus.o_switch), 64'(byp));
    chk("start_err",  64'(o_cfg_err), 64'd0);

    while (k < NUM && !aborted) begin
      if (cyc > 200) begin
        chk("stream_timeout", 64'(k), 64'(NUM));
        break;
      end
      case (vmode)
        0:       bus.i_s_valid = 1'b1;
        1:       bus.i_s_valid = (cyc % 3 == 0);
        default: bus.i_s_valid = 1'($urandom_range(0, 1));
      endcase
      samp = fixed_data ? SW'(32'h0001_0002 + k) : SW'($urandom);
      bus.i_s_data = samp;
      if (abort_at >= 0 && k == abort_at) i_abort = 1'b1;
      if (cfg_run && cyc == 1) begin
        i_cfg_we = 1'b1; i_cfg_addr = AW'(2); i_cfg_wdata = 48'hAB_CDEF;
      end
      acc = bus.i_s_valid && !i_abort;
      @(negedge clk);
      chk("x0_valid", 64'(bus.o_x0_valid), 64'(acc));
      if (acc) begin
        chk("x0_data", 64'(bus.o_x0_data), 64'(samp));
        chk("x0_w",    64'(bus.o_w), 64'(m_tbl[k]));
        m_idx = k;
        k++;
      end
      chk("x0_idx", 64'(bus.o_idx), 64'(m_idx));
      chk("run_sw", 64'(bus.o_switch), 64'(byp));
      if (cfg_run && cyc == 1) chk("cfg_run_err", 64'(o_cfg_err), 64'd1);
      if (i_abort) begin
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_rdy",  64'(bus.o_s_ready), 64'd0);
        aborted = 1;
      end else begin
        chk("run_rdy", 64'(bus.o_s_ready), 64'(k < NUM));
      end
      i_abort = 1'b0; i_cfg_we = 1'b0;
      cyc++;
    end
    bus.i_s_valid = 1'b0;

    if (aborted) begin
      for (int d = 0; d < 10; d++) begin
        @(negedge clk);
        chk("abort_no_done", 64'(o_done), 64'd0);
        chk("abort_valid",   64'(bus.o_x0_valid), 64'd0);
      end
    end else begin
      lat = byp ? LR : LC;
      for (int d = 1; d <= lat; d++) begin
        if (rst_drain && d == 2) begin
          rst_n = 1'b0;
          @(negedge clk);
          chk_all_zero("rst_drain");
          rst_n = 1'b1;
          m_idx = 0;
          break;
        end
        @(negedge clk);
        chk("drain_done",  64'(o_done), 64'(d == lat));
        chk("drain_busy",  64'(o_busy), 64'(d < lat));
        chk("drain_valid", 64'(bus.o_x0_valid), 64'd0);
        chk("drain_sw",    64'(bus.o_switch), 64'(byp));
      end
      @(negedge clk);
      chk("post_done", 64'(o_done), 64'd0);
    end
    $display("frame %s: bypass=%0d accepts=%0d cycles=%0d aborted=%0d", name, byp, k, cyc, aborted);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_bypass = 1'b0; i_abort = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0;
    bus.i_s_data = '0; bus.i_s_valid = 1'b0;
    m_idx = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NUM; k++) cfg_write(k, TW'(k + 1));

    run_frame("basic_complex", 1'b0, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("bypass",        1'b1, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("stalls",        1'b0, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("cfg_in_run",    1'b1, 2, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("abort",         1'b0, 0,  3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("wr_and_start",  1'b0, 2, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame("rst_in_drain",  1'b1, 0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("after_reset",   1'b0, 2, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
